pid_sub_scheduler: RTL and testbench

PID_SUB_SCHEDULER -- requirements
Module: pid_sub_scheduler

---
 rtl/pid_sub_scheduler.sv | 118 +++++++++++
 tb/tb_pid_sub_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_sub_scheduler.sv
// pid_sub_scheduler: one complement-then-add subtractor shared round-robin
// among NREQ requesters (P-error, I-delta, D-delta). One operation runs at
// a time, and each operation takes four cycles from the grant to the ack.
//
// Handshake: req[i] is a level request. The requester holds it, with its
// operands on a_bus/b_bus, until the grant edge. Operands are captured only
// at that edge. ack[i] is a one-cycle pulse in the cycle after the DONE
// state. If req[i] is still high during that ack cycle, it counts as a new
// request at the next IDLE evaluation. Dropping req early does not cancel
// an operation that is already in flight.
module pid_sub_scheduler #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_bus,
  input  logic [NREQ*WIDTH-1:0] b_bus,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      result,
  output logic                  ovf,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COMP = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   pick;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic [WIDTH-1:0] comp_reg;
  logic [WIDTH-1:0] sum;

  // Round-robin pick: the first requester found, starting at last_grant+1 and wrapping around.
  always_comb begin
    logic [GW-1:0] idx;
    pick = last_grant;
    idx  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = GW'((int'(last_grant) + k) % NREQ);
      if (req[idx]) pick = idx;
    end
  end

  assign sum = a_lat + comp_reg;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: wait in IDLE for any request, then walk COMP -> ADD -> DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = COMP;
      COMP:    state_nxt = ADD;
      ADD:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: busy in every state except IDLE; the raw state is exposed for debug.
  always_comb begin
    busy      = (state != IDLE);
    dbg_state = state;
  end

  // Datapath: latch at grant, two's-complement b, add, then pulse ack and rotate priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant      <= '0;
      last_grant <= GW'(NREQ - 1);
      a_lat      <= '0;
      b_lat      <= '0;
      comp_reg   <= '0;
      result     <= '0;
      ovf        <= 1'b0;
      ack        <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            grant <= pick;
            a_lat <= a_bus[int'(pick)*WIDTH +: WIDTH];
            b_lat <= b_bus[int'(pick)*WIDTH +: WIDTH];
          end
        end
        COMP: comp_reg <= ~b_lat + WIDTH'(1);
        ADD: begin
          result <= sum;
          ovf    <= (a_lat[WIDTH-1] != b_lat[WIDTH-1]) && (sum[WIDTH-1] != a_lat[WIDTH-1]);
        end
        DONE: begin
          ack        <= NREQ'(1) << grant;
          last_grant <= grant;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pid_sub_scheduler.sv
// Self-checking bench for pid_sub_scheduler: directed vectors plus randomized
// traffic compared against a cycle-count reference model.
module tb_pid_sub_scheduler;

  localparam int WIDTH = 16;
  localparam int NREQ  = 3;
  localparam int QW    = 2 + WIDTH + 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_bus;
  logic [NREQ*WIDTH-1:0] b_bus;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      result;
  logic                  ovf;
  logic                  busy;
  logic [1:0]            dbg_state;

  pid_sub_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_bus(a_bus), .b_bus(b_bus),
    .ack(ack), .result(result), .ovf(ovf), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int              m_last;
  int              m_free;
  int              edge_n;
  logic [QW-1:0]   exp_q[$];
  int              due_q[$];
  int              ack_log[$];
  int              ack_edge[$];

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        ov;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Subtraction in integer arithmetic: overflow means the true difference does not fit the signed range.
  function automatic logic [QW-1:0] ref_op(input int idx, input logic [15:0] a, input logic [15:0] b);
    int sa, sb, d;
    logic [15:0] r;
    logic        v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    d  = sa - sb;
    r  = d[15:0];
    v  = (d > 32767) || (d < -32768);
    return {2'(idx), r, v};
  endfunction

  function automatic logic [15:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'h7FFF;
      3: return 16'hFFFF;
      default: return 16'($urandom());
    endcase
  endfunction

  // Model, applied at each rising edge: when the unit is free and any req is high, grant round-robin.
  task automatic model_edge();
    int j;
    bit found;
    found = 0;
    j = 0;
    if (edge_n >= m_free && |req) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (!found && req[(m_last + k) % NREQ]) begin
          j = (m_last + k) % NREQ;
          found = 1;
        end
      end
      exp_q.push_back(ref_op(j, a_bus[j*WIDTH +: WIDTH], b_bus[j*WIDTH +: WIDTH]));
      due_q.push_back(edge_n + 3);
      m_free = edge_n + 4;
      m_last = j;
    end
  endtask

  // Scoreboard compare, made at the falling edge after each rising edge.
  task automatic check_outputs();
    logic [QW-1:0] e;
    logic [2:0]    e_ack;
    if (ack != '0) begin
      ack_log.push_back(int'(ack));
      ack_edge.push_back(edge_n);
    end
    check("busy", busy, (edge_n < m_free - 1));
    if (due_q.size() > 0 && due_q[0] == edge_n) begin
      void'(due_q.pop_front());
      e = exp_q.pop_front();
      e_ack = 3'b001 << e[QW-1 -: 2];
      check($sformatf("rand_ack@%0d", edge_n), ack, e_ack);
      check($sformatf("rand_result@%0d", edge_n), result, e[WIDTH:1]);
      check($sformatf("rand_ovf@%0d", edge_n), ovf, e[0]);
    end else begin
      check($sformatf("rand_noack@%0d", edge_n), ack, 3'b000);
    end
  endtask

  // mode 0: random traffic, 1: all requests held with fixed operands, 2: drain (no new requests)
  task automatic run_cycles(input int n, input int mode);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      edge_n++;
      model_edge();
      @(negedge clk);
      check_outputs();
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && ack[i]) begin
          if (!(mode == 1 || (mode == 0 && $urandom_range(0, 3) == 0))) req[i] = 1'b0;
        end else if (!req[i] && mode == 0 && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
        end
        if (mode != 1) begin
          a_bus[i*WIDTH +: WIDTH] = rand_opnd();
          b_bus[i*WIDTH +: WIDTH] = rand_opnd();
        end
      end
    end
  endtask

  // One request from idle: check ack timing and busy length, and scramble the operands while the operation is in flight.
  task automatic run_single(input int v);
    int ack_cyc, busy_cnt;
    logic [2:0] ack_val;
    ack_cyc = 0;
    busy_cnt = 0;
    ack_val = '0;
    req = 3'b001 << vecs[v].idx;
    a_bus[vecs[v].idx*WIDTH +: WIDTH] = vecs[v].a;
    b_bus[vecs[v].idx*WIDTH +: WIDTH] = vecs[v].b;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1) req = '0;
      if (c <= 2) begin
        a_bus = {3{16'($urandom())}};
        b_bus = {3{16'($urandom())}};
      end
      if (busy) busy_cnt++;
      if (ack != '0 && ack_cyc == 0) begin
        ack_cyc = c;
        ack_val = ack;
        check($sformatf("vec%0d_result", v), result, vecs[v].res);
        check($sformatf("vec%0d_ovf", v), ovf, vecs[v].ov);
      end
    end
    check($sformatf("vec%0d_ack_cycle", v), ack_cyc, 4);
    check($sformatf("vec%0d_ack", v), ack_val, 3'b001 << vecs[v].idx);
    check($sformatf("vec%0d_busy_cycles", v), busy_cnt, 3);
  endtask

  initial begin
    int first_ack, first_cyc;
    int exp_order[6];
    vecs[0] = '{0, 16'h0005, 16'h0003, 16'h0002, 1'b0};
    vecs[1] = '{0, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1};
    vecs[2] = '{0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1};
    vecs[3] = '{0, 16'h1234, 16'h0000, 16'h1234, 1'b0};
    vecs[4] = '{0, 16'h0000, 16'h8000, 16'h8000, 1'b1};
    vecs[5] = '{1, 16'h8000, 16'h8000, 16'h0000, 1'b0};
    vecs[6] = '{2, 16'h0010, 16'h0020, 16'hFFF0, 1'b0};
    vecs[7] = '{1, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0};
    vecs[8] = '{0, 16'h4000, 16'hC000, 16'h8000, 1'b1};
    exp_order = '{1, 2, 4, 1, 2, 4};

    // reset state
    rst_n = 1'b0;
    req   = '0;
    a_bus = '0;
    b_bus = '0;
    #12;
    check("rst_ack", ack, 3'b000);
    check("rst_result", result, 16'h0000);
    check("rst_ovf", ovf, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, 2'd0);

    // fairness: all requests held from the first edge after reset release
    req   = 3'b111;
    a_bus = {16'h0300, 16'h0200, 16'h0100};
    b_bus = {16'h0030, 16'h0020, 16'h0010};
    @(negedge clk);
    rst_n  = 1'b1;
    edge_n = 0;
    m_last = NREQ - 1;
    m_free = 0;
    run_cycles(24, 1);
    check("fair_ack_count", (ack_log.size() >= 6), 1'b1);
    if (ack_log.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("fair_order%0d", i), ack_log[i], exp_order[i]);
        check($sformatf("fair_edge%0d", i), ack_edge[i], 4 * (i + 1));
      end
    end

    // randomized traffic, then drain
    run_cycles(600, 0);
    run_cycles(40, 2);
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_req_idle", req, 3'b000);

    // directed vectors
    for (int v = 0; v < 9; v++) run_single(v);

    // reset during ADD
    req = 3'b001;
    a_bus[0 +: WIDTH] = 16'h0005;
    b_bus[0 +: WIDTH] = 16'h0003;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("midop_in_add", dbg_state, 2'd2);
    #2 rst_n = 1'b0;
    #1;
    check("midop_rst_ack", ack, 3'b000);
    check("midop_rst_result", result, 16'h0000);
    check("midop_rst_ovf", ovf, 1'b0);
    check("midop_rst_busy", busy, 1'b0);
    req   = 3'b110;
    a_bus = {16'h0050, 16'h0900, 16'h0001};
    b_bus = {16'h0010, 16'h0100, 16'h0001};
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    first_ack = 0;
    first_cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack != '0 && first_cyc == 0) begin
        first_cyc = c;
        first_ack = int'(ack);
        check("midop_after_result", result, 16'h0800);
      end
    end
    check("midop_first_ack", first_ack, 2);
    check("midop_first_cycle", first_cyc, 4);
    req = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
